mb_rd_sched: RTL

Read-side scheduler for the 4-queue metadata buffer. It watches the per-queue empty flags and gate-open mask, then picks one queue by strict priority (q0 > q1 > q2 > q3). It issues a single-cycle read enable to that queue and captures the returned 8-bit metadata. It forwards the metadata to the output scheduler and holds off until that packet's transmission completes. It sits between the metadata buffer (reader side) and the transmit/output stage, with guard-band checking for queue 2 using the head packet length.

---
 rtl/mb_rd_sched.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mb_rd_sched.sv
// Read-side scheduler for the 4-queue metadata buffer: strict-priority queue pick,
// single outstanding read, metadata forward, then hold until the packet is transmitted.
module mb_rd_sched #(
   parameter logic [10:0] GB_MARGIN  = 11'd8,
   parameter int          MD_TIMEOUT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_sched_en,
   input  logic [3:0]  in_sched_fifo_empty,
   input  logic [3:0]  in_sched_gate_open,
   input  logic [10:0] in_sched_pkt_len,
   input  logic [15:0] in_sched_gate_remain,
   output logic        out_sched_q0_rden,
   output logic        out_sched_q1_rden,
   output logic        out_sched_q2_rden,
   output logic        out_sched_q3_rden,
   input  logic [7:0]  in_sched_md,
   input  logic        in_sched_md_wr,
   output logic [7:0]  out_sched_md,
   output logic        out_sched_md_wr,
   output logic [1:0]  out_sched_qid,
   input  logic        in_sched_tx_done,
   output logic        out_sched_busy,
   output logic [7:0]  out_sched_err_cnt,
   output logic [15:0] out_sched_pkt_cnt
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WAIT_MD = 2'd1;
   localparam logic [1:0] ST_WAIT_TX = 2'd2;

   localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
   localparam logic [TW-1:0] WAIT_LAST = TW'(MD_TIMEOUT - 1);

   logic [1:0]    state_q;
   logic [TW-1:0] wait_q;
   logic [1:0]    qid_q;
   logic [7:0]    md_q;
   logic          md_wr_q;
   logic [7:0]    err_q;
   logic [15:0]   pkt_cnt_q;

   logic [15:0]   q2_need;
   logic [3:0]    elig;
   logic [1:0]    pick;
   logic          issue;
   logic [3:0]    rden;

   // Queue 2 must finish before the gate window closes; both terms fit in 12 bits, so no overflow at 16.
   always_comb begin
      q2_need = {5'b0, in_sched_pkt_len} + {5'b0, GB_MARGIN};
      elig    = ~in_sched_fifo_empty & in_sched_gate_open;
      elig[2] = elig[2] & (q2_need <= in_sched_gate_remain);
   end

   // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      pick  = 2'd3;
      rden  = 4'b0000;
      if (elig[0])      pick = 2'd0;
      else if (elig[1]) pick = 2'd1;
      else if (elig[2]) pick = 2'd2;
      issue = (state_q == ST_IDLE) & ~rst & in_sched_en & (|elig);
      if (issue) rden[pick] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         qid_q     <= 2'd0;
         md_q      <= 8'h00;
         md_wr_q   <= 1'b0;
         err_q     <= 8'h00;
         pkt_cnt_q <= 16'h0000;
      end else begin
         md_wr_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (issue) begin
                  qid_q   <= pick;
                  wait_q  <= '0;
                  state_q <= ST_WAIT_MD;
               end
            end
            ST_WAIT_MD: begin
               if (in_sched_md_wr) begin
                  md_q      <= in_sched_md;
                  md_wr_q   <= 1'b1;
                  pkt_cnt_q <= pkt_cnt_q + 16'd1;
                  state_q   <= ST_WAIT_TX;
               end else if (wait_q == WAIT_LAST) begin
                  if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                  state_q <= ST_IDLE;
               end else begin
                  wait_q <= wait_q + TW'(1);
               end
            end
            // The forward-strobe cycle is already WAIT_TX, so a same-cycle tx_done completes the packet.
            ST_WAIT_TX: begin
               if (in_sched_tx_done) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_sched_q0_rden = rden[0];
   assign out_sched_q1_rden = rden[1];
   assign out_sched_q2_rden = rden[2];
   assign out_sched_q3_rden = rden[3];
   assign out_sched_md      = md_q;
   assign out_sched_md_wr   = md_wr_q;
   assign out_sched_qid     = qid_q;
   assign out_sched_busy    = (state_q != ST_IDLE);
   assign out_sched_err_cnt = err_q;
   assign out_sched_pkt_cnt = pkt_cnt_q;

endmodule
